instruction_fetch: RTL and testbench

Instruction Fetch stage of the 5-stage MIPS pipeline: holds the PC, reads the instruction memory combinationally and produces the instruction, PC+4 (NPC) and PC+8 (branch-delay-slot / link address) consumed by the IF/ID pipeline register. It also contains the byte-serial program loader that the debug unit uses to fill instruction memory before execution. The stage halts itself on the HALT word.

---
 rtl/pipeline_pkg.sv | 6 +
 rtl/instruction_memory.sv | 17 +
 rtl/instruction_fetch.sv | 61 ++++++
 tb/tb_instruction_fetch.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the MIPS pipeline stages
package pipeline_pkg;
  localparam logic [1:0] NPC_SEQ = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JR = 2'b11;
  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF, NOP_INST = 32'h0000_0000;
  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, BYTE3} load_state_t;
endpackage

// File: rtl/instruction_memory.sv
// instruction_memory: zero-initialised word memory, async read, sync write
module instruction_memory #(
  parameter int INST_SZ = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SZ = $clog2(MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [INST_SZ-1:0] i_wdata,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic [INST_SZ-1:0] o_rdata
);
  logic [INST_SZ-1:0] r_mem [MEM_DEPTH] = '{default: '0};
  always_ff @(posedge i_clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, next-PC mux, instruction read and byte-serial program loader
import pipeline_pkg::*;
module instruction_fetch #(
  parameter int INST_SZ = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SZ = $clog2(MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [1:0]         i_next_pc_src,
  input  logic [INST_SZ-1:0] i_branch_addr,
  input  logic [INST_SZ-1:0] i_jump_addr,
  input  logic [INST_SZ-1:0] i_rs_addr,
  input  logic               i_load_valid,
  input  logic [7:0]         i_load_byte,
  output logic [INST_SZ-1:0] o_instruction,
  output logic [INST_SZ-1:0] o_npc,
  output logic [INST_SZ-1:0] o_bds,
  output logic [INST_SZ-1:0] o_pc,
  output logic               o_halt,
  output logic               o_mem_full
);
  logic [INST_SZ-1:0] r_pc, w_next_pc;
  logic [ADDR_SZ:0]   r_wptr;
  logic [23:0]        r_word;
  load_state_t        r_state;
  logic               w_we;
  assign o_pc = r_pc;
  assign o_npc = r_pc + INST_SZ'(4);
  assign o_bds = r_pc + INST_SZ'(8);
  assign o_halt = o_instruction == INST_SZ'(HALT_INST);
  assign o_mem_full = r_wptr[ADDR_SZ];
  assign w_we = i_load_valid && !o_mem_full && r_state == BYTE3 && !i_reset;
  always_comb
    w_next_pc = i_next_pc_src == NPC_BRANCH ? i_branch_addr :
                i_next_pc_src == NPC_JUMP   ? i_jump_addr :
                i_next_pc_src == NPC_JR     ? i_rs_addr : o_npc;
  always_ff @(posedge i_clk)
    if (i_reset) r_pc <= '0;
    else if (i_enable && !o_halt) r_pc <= w_next_pc;
  // BYTE3 + 1 wraps back to BYTE0, so the state simply counts strobes
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_state <= BYTE0;
      r_word <= '0;
      r_wptr <= '0;
    end else if (i_load_valid && !o_mem_full) begin
      r_state <= load_state_t'(r_state + 2'd1);
      r_word <= {r_word[15:0], i_load_byte};
      if (r_state == BYTE3) r_wptr <= r_wptr + (ADDR_SZ+1)'(1);
    end
  instruction_memory #(.INST_SZ(INST_SZ), .MEM_DEPTH(MEM_DEPTH), .ADDR_SZ(ADDR_SZ)) u_mem (
    .i_clk(i_clk),
    .i_we(w_we),
    .i_waddr(r_wptr[ADDR_SZ-1:0]),
    .i_wdata(INST_SZ'({r_word, i_load_byte})),
    .i_raddr(r_pc[ADDR_SZ+1:2]),
    .o_rdata(o_instruction)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed + random stimulus against a word/byte-queue reference model
module tb_instruction_fetch;
  logic        i_clk = 0, i_reset = 0, i_enable = 0, i_load_valid = 0;
  logic [1:0]  i_next_pc_src = 0;
  logic [31:0] i_branch_addr = 0, i_jump_addr = 0, i_rs_addr = 0;
  logic [7:0]  i_load_byte = 0;
  logic [31:0] o_instruction, o_npc, o_bds, o_pc;
  logic        o_halt, o_mem_full;
  int n_checks = 0, n_errors = 0;
  logic [31:0] m_mem [256];
  logic [31:0] m_pc = 0;
  int          m_wptr = 0;
  logic [7:0]  m_q [$];
  always #5 i_clk = ~i_clk;
  instruction_fetch dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_next_pc_src(i_next_pc_src),
    .i_branch_addr(i_branch_addr), .i_jump_addr(i_jump_addr), .i_rs_addr(i_rs_addr),
    .i_load_valid(i_load_valid), .i_load_byte(i_load_byte), .o_instruction(o_instruction),
    .o_npc(o_npc), .o_bds(o_bds), .o_pc(o_pc), .o_halt(o_halt), .o_mem_full(o_mem_full)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] m_inst();
    return m_mem[m_pc[9:2]];
  endfunction
  task automatic model_step();
    logic [31:0] tgt;
    if (i_reset) begin
      m_pc = 0;
      m_wptr = 0;
      m_q.delete();
      return;
    end
    tgt = i_next_pc_src == 2'd1 ? i_branch_addr : i_next_pc_src == 2'd2 ? i_jump_addr :
          i_next_pc_src == 2'd3 ? i_rs_addr : m_pc + 4;
    if (i_enable && m_inst() != 32'hFFFF_FFFF) m_pc = tgt;
    if (i_load_valid && m_wptr < 256) begin
      m_q.push_back(i_load_byte);
      if (m_q.size() == 4) begin
        m_mem[m_wptr] = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_wptr++;
        m_q.delete();
      end
    end
  endtask
  task automatic check_all();
    chk("pc", o_pc, m_pc);
    chk("npc", o_npc, m_pc + 4);
    chk("bds", o_bds, m_pc + 8);
    chk("instruction", o_instruction, m_inst());
    chk("halt", {31'b0, o_halt}, {31'b0, m_inst() == 32'hFFFF_FFFF});
    chk("mem_full", {31'b0, o_mem_full}, {31'b0, m_wptr == 256});
  endtask
  task automatic cycle();
    @(posedge i_clk);
    model_step();
    #1;
    check_all();
    i_reset = 0;
    i_load_valid = 0;
  endtask
  task automatic load_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) begin
      i_load_valid = 1;
      i_load_byte = w[b*8 +: 8];
      cycle();
    end
  endtask
  initial begin
    for (int k = 0; k < 256; k++) m_mem[k] = 0;
    i_reset = 1;
    cycle();
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_npc", o_npc, 32'h4);
    chk("rst_bds", o_bds, 32'h8);
    chk("rst_inst", o_instruction, 32'h0);
    i_enable = 1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("seq_pc", o_pc, 32'(4 * k));
    end
    i_reset = 1;
    cycle();
    i_enable = 0;
    load_word(32'h2008_0005);
    chk("load_word0", o_instruction, 32'h2008_0005);
    load_word(32'h1234_5678);
    i_enable = 1;
    i_next_pc_src = 2'd1;
    i_branch_addr = 32'h40;
    cycle();
    chk("branch_pc", o_pc, 32'h40);
    i_next_pc_src = 2'd3;
    i_rs_addr = 32'h404;
    cycle();
    chk("jr_wrap_inst", o_instruction, 32'h1234_5678);
    i_next_pc_src = 2'd2;
    i_jump_addr = 32'h8;
    cycle();
    i_enable = 0;
    i_next_pc_src = 2'd1;
    i_branch_addr = 32'h100;
    cycle();
    cycle();
    chk("stall_pc", o_pc, 32'h8);
    i_reset = 1;
    cycle();
    for (int k = 0; k < 3; k++) load_word($urandom & 32'h7FFF_FFFF);
    load_word(32'hFFFF_FFFF);
    i_enable = 1;
    i_next_pc_src = 2'd0;
    for (int k = 0; k < 6; k++) cycle();
    chk("halt_pc", o_pc, 32'hC);
    chk("halt_flag", {31'b0, o_halt}, 32'h1);
    i_reset = 1;
    cycle();
    chk("halt_reset_pc", o_pc, 32'h0);
    i_enable = 0;
    i_load_valid = 1; i_load_byte = 8'h11; cycle();
    i_load_valid = 1; i_load_byte = 8'h22; cycle();
    i_reset = 1;
    cycle();
    load_word(32'hAABB_CCDD);
    chk("reload_word0", o_instruction, 32'hAABB_CCDD);
    for (int k = 1; k < 256; k++) load_word($urandom & 32'h7FFF_FFFF);
    chk("mem_full_set", {31'b0, o_mem_full}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      i_load_valid = 1;
      i_load_byte = 8'hFF;
      cycle();
    end
    chk("full_drop_word0", o_instruction, 32'hAABB_CCDD);
    i_enable = 1;
    i_next_pc_src = 2'd2;
    for (int k = 0; k < 256; k++) begin
      i_jump_addr = ($urandom & 32'hFFFF_FC03) | 32'(k << 2);
      cycle();
    end
    for (int k = 0; k < 600; k++) begin
      i_reset = $urandom_range(0, 39) == 0;
      i_enable = $urandom_range(0, 3) != 0;
      i_next_pc_src = 2'($urandom);
      i_branch_addr = $urandom;
      i_jump_addr = $urandom;
      i_rs_addr = $urandom;
      i_load_valid = $urandom_range(0, 1) == 1;
      i_load_byte = $urandom_range(0, 9) == 0 ? 8'hFF : 8'($urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
